// File: rtl/angle_normalizer_pkg.sv
// Shared range-reduction definitions: pi constants derived from the fraction
// width, quadrant (flip) encodings used by the result converter, FSM states.
package angle_normalizer_pkg;

    // round(pi/2 * 2^frac) and round(pi/4 * 2^frac) with 9-digit scaled constants
    function automatic int pi_2_lsb(input int frac);
        longint scaled;
        scaled = (64'sd1570796327 * (64'sd1 <<< frac) + 64'sd500000000) / 64'sd1000000000;
        return int'(scaled);
    endfunction

    function automatic int pi_4_lsb(input int frac);
        longint scaled;
        scaled = (64'sd785398163 * (64'sd1 <<< frac) + 64'sd500000000) / 64'sd1000000000;
        return int'(scaled);
    endfunction

    localparam logic [2:0] FLIP_ZERO = 3'b000;
    localparam logic [2:0] FLIP_POS1 = 3'b001;
    localparam logic [2:0] FLIP_POS2 = 3'b010;
    localparam logic [2:0] FLIP_NEG1 = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_REDUCE = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

endpackage

// File: rtl/angle_normalizer.sv
// Iterative +/-pi/2 range reduction of a signed fixed-point angle into
// [-pi/4, +pi/4], emitting the residual and a wrapped quadrant code.
module angle_normalizer
    import angle_normalizer_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 12,
    parameter int PI_2  = pi_2_lsb(FRAC),
    parameter int PI_4  = pi_4_lsb(FRAC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] angle_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] angle_out,
    output logic [2:0]       flip,
    output logic             busy
);

    localparam logic signed [WIDTH:0] PI_2_S     = (WIDTH+1)'(PI_2);
    localparam logic signed [WIDTH:0] PI_4_S     = (WIDTH+1)'(PI_4);
    localparam logic signed [WIDTH:0] NEG_PI_4_S = (WIDTH+1)'(-PI_4);

    // Only the turn count modulo 4 matters: +2 and -2 both land on FLIP_POS2.
    function automatic logic [2:0] wrap_turns(input logic [1:0] turns_mod4);
        logic [2:0] code;
        case (turns_mod4)
            2'd0:    code = FLIP_ZERO;
            2'd1:    code = FLIP_POS1;
            2'd2:    code = FLIP_POS2;
            2'd3:    code = FLIP_NEG1;
            default: code = FLIP_ZERO;
        endcase
        return code;
    endfunction

    state_e                   state_r, state_nxt_s;
    logic signed [WIDTH:0]    acc_r, acc_nxt_s;
    logic signed [3:0]        k_r, k_nxt_s;
    logic        [WIDTH-1:0]  angle_out_r, angle_out_nxt_s;
    logic        [2:0]        flip_r, flip_nxt_s;
    logic                     out_valid_r, out_valid_nxt_s;
    logic                     in_ready_r, in_ready_nxt_s;
    logic                     busy_r, busy_nxt_s;

    // Next-state and next-output logic: one reduction decision per REDUCE cycle
    always_comb begin
        state_nxt_s     = state_r;
        acc_nxt_s       = acc_r;
        k_nxt_s         = k_r;
        angle_out_nxt_s = angle_out_r;
        flip_nxt_s      = flip_r;
        out_valid_nxt_s = out_valid_r;
        in_ready_nxt_s  = in_ready_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && in_ready_r) begin
                    acc_nxt_s      = {angle_in[WIDTH-1], angle_in};
                    k_nxt_s        = 4'sd0;
                    state_nxt_s    = ST_REDUCE;
                    in_ready_nxt_s = 1'b0;
                end else begin
                    in_ready_nxt_s = 1'b1;
                end
            end
            ST_REDUCE: begin
                if (acc_r > PI_4_S) begin
                    acc_nxt_s = acc_r - PI_2_S;
                    k_nxt_s   = k_r + 4'sd1;
                end else if (acc_r < NEG_PI_4_S) begin
                    acc_nxt_s = acc_r + PI_2_S;
                    k_nxt_s   = k_r - 4'sd1;
                end else begin
                    // Residual is within +/-PI_4 here, so the low WIDTH bits are exact
                    state_nxt_s     = ST_DONE;
                    angle_out_nxt_s = acc_r[WIDTH-1:0];
                    flip_nxt_s      = wrap_turns(k_r[1:0]);
                    out_valid_nxt_s = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s     = ST_IDLE;
                    out_valid_nxt_s = 1'b0;
                    in_ready_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                out_valid_nxt_s = 1'b0;
                in_ready_nxt_s  = 1'b1;
            end
        endcase
        busy_nxt_s = (state_nxt_s == ST_REDUCE);
    end

    // State and registered-output update; reset aborts any reduction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            acc_r       <= '0;
            k_r         <= 4'sd0;
            angle_out_r <= '0;
            flip_r      <= FLIP_ZERO;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            acc_r       <= acc_nxt_s;
            k_r         <= k_nxt_s;
            angle_out_r <= angle_out_nxt_s;
            flip_r      <= flip_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            in_ready_r  <= in_ready_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign angle_out = angle_out_r;
    assign flip      = flip_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_angle_normalizer.sv
// Self-checking bench for angle_normalizer: directed corner angles, random
// angles against a closed-form reduction model, backpressure and reset abort.
module tb_angle_normalizer;

    localparam int W  = 16;
    localparam int P2 = 6434;
    localparam int P4 = 3217;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  angle_in;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  angle_out;
    logic [2:0]    flip;
    logic          busy;

    int errors = 0;
    int checks = 0;

    angle_normalizer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .angle_in(angle_in), .out_valid(out_valid), .out_ready(out_ready),
        .angle_out(angle_out), .flip(flip), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Turn count from a closed form: smallest |k| leaving x - k*P2 within [-P4, P4]
    function automatic int model_k(input int x);
        if (x > P4) return (x - P4 + P2 - 1) / P2;
        else if (x < -P4) return -((-x - P4 + P2 - 1) / P2);
        else return 0;
    endfunction

    function automatic logic [2:0] model_flip(input int k);
        int m;
        m = ((k % 4) + 4) % 4;
        if (m == 0) return 3'b000;
        else if (m == 1) return 3'b001;
        else if (m == 2) return 3'b010;
        else return 3'b101;
    endfunction

    // One full transaction; reports observed residual, flip and latency (edges after accept)
    task automatic run_one(input int x, input bit early, output int got_out,
                           output logic [2:0] got_flip, output int got_lat, output bit got_ok);
        bit seen;
        int lat;
        int k_m;
        k_m = model_k(x);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_ready x=%0d got=%b exp=1", x, in_ready); end
        in_valid  = 1'b1;
        angle_in  = W'(x);
        out_ready = early;
        @(posedge clk); #1;
        in_valid = 1'b0;
        angle_in = W'($urandom);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL accept_state x=%0d in_ready=%b busy=%b exp 0/1", x, in_ready, busy);
        end
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 20) begin
            if (out_valid === 1'b1) seen = 1'b1;
            else begin @(posedge clk); #1; lat++; end
        end
        got_out  = $signed(angle_out);
        got_flip = flip;
        got_lat  = lat;
        got_ok   = seen;
        checks++;
        if (!seen) begin errors++; $display("FAIL timeout x=%0d no out_valid within 20 cycles", x); end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL done_state x=%0d busy=%b in_ready=%b exp 0/0", x, busy, in_ready);
        end
        checks++;
        if (got_out + k_m * P2 != x) begin
            errors++; $display("FAIL invariant x=%0d got=%0d+%0d*%0d exp=%0d", x, got_out, k_m, P2, x);
        end
        if (!early) begin @(negedge clk); out_ready = 1'b1; end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || $signed(angle_out) != got_out || flip !== got_flip) begin
            errors++;
            $display("FAIL handshake x=%0d out_valid=%b in_ready=%b angle_out=%0d flip=%b exp 0/1/%0d/%b",
                     x, out_valid, in_ready, $signed(angle_out), flip, got_out, got_flip);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; angle_in = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || angle_out !== 16'd0 || flip !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values in_ready=%b out_valid=%b angle_out=%0d flip=%b busy=%b exp 1/0/0/000/0",
                     in_ready, out_valid, angle_out, flip, busy);
        end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_directed;
        int xs[8]       = '{0, 6434, -12868, 3217, -3217, 3218, 32767, -32768};
        int outs[8]     = '{0, 0, 0, 3217, -3217, -3216, 597, -598};
        logic [2:0] fl[8] = '{3'b000, 3'b001, 3'b010, 3'b000, 3'b000, 3'b001, 3'b001, 3'b101};
        int lats[8]     = '{1, 2, 3, 1, 1, 2, 6, 6};
        int go; logic [2:0] gf; int gl; bit ok;
        for (int i = 0; i < 8; i++) begin
            run_one(xs[i], 1'b0, go, gf, gl, ok);
            checks++;
            if (ok && (go != outs[i] || gf !== fl[i] || gl != lats[i])) begin
                errors++;
                $display("FAIL directed x=%0d got out=%0d flip=%b lat=%0d exp out=%0d flip=%b lat=%0d",
                         xs[i], go, gf, gl, outs[i], fl[i], lats[i]);
            end
        end
    endtask

    task automatic test_random;
        int go; logic [2:0] gf; int gl; bit ok;
        int x, k;
        for (int i = 0; i < 40; i++) begin
            x = int'($signed(16'($urandom)));
            k = model_k(x);
            run_one(x, 1'($urandom_range(0, 1)), go, gf, gl, ok);
            checks++;
            if (ok && (go != x - k * P2 || gf !== model_flip(k) || gl != (k < 0 ? -k : k) + 1)) begin
                errors++;
                $display("FAIL random x=%0d got out=%0d flip=%b lat=%0d exp out=%0d flip=%b lat=%0d",
                         x, go, gf, gl, x - k * P2, model_flip(k), (k < 0 ? -k : k) + 1);
            end
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        @(negedge clk);
        in_valid = 1'b1; angle_in = 16'd6434; out_ready = 1'b0;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (out_valid !== 1'b1 && cyc < 20);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_timeout no out_valid within 20 cycles"); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            angle_in = W'($urandom);
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || angle_out !== 16'd0 || flip !== 3'b001 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d out_valid=%b angle_out=%0d flip=%b in_ready=%b exp 1/0/001/0",
                         i, out_valid, angle_out, flip, in_ready);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release out_valid=%b in_ready=%b busy=%b exp 0/1/0", out_valid, in_ready, busy);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        int go; logic [2:0] gf; int gl; bit ok;
        int xs[3] = '{-6435, 9651, 19302};
        for (int i = 0; i < 3; i++) begin
            run_one(xs[i], 1'b1, go, gf, gl, ok);
            checks++;
            if (ok && (go != xs[i] - model_k(xs[i]) * P2 || gf !== model_flip(model_k(xs[i])))) begin
                errors++;
                $display("FAIL b2b x=%0d got out=%0d flip=%b exp out=%0d flip=%b",
                         xs[i], go, gf, xs[i] - model_k(xs[i]) * P2, model_flip(model_k(xs[i])));
            end
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        in_valid = 1'b1; angle_in = 16'd32767;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || angle_out !== 16'd0 || flip !== 3'b000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid in_ready=%b out_valid=%b angle_out=%0d flip=%b busy=%b exp 1/0/0/000/0",
                     in_ready, out_valid, angle_out, flip, busy);
        end
        @(negedge clk); rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_discard out_valid=%b busy=%b in_ready=%b exp 0/0/1", out_valid, busy, in_ready);
        end
    endtask

    initial begin
        int go; logic [2:0] gf; int gl; bit ok;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        run_one(-32768, 1'b0, go, gf, gl, ok);
        checks++;
        if (ok && (go != -598 || gf !== 3'b101)) begin
            errors++; $display("FAIL post_reset got out=%0d flip=%b exp out=-598 flip=101", go, gf);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
